// File: rtl/design_mux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | design_mux_pkg : FSM states and register map for design_select_mux |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package design_mux_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      ISOLATE = 2'd1,
      RESET   = 2'd2
   } mux_state_e;

   localparam logic [3:0] CTRL_OFS   = 4'h0;
   localparam logic [3:0] STATUS_OFS = 4'h4;

   localparam int CTRL_TARGET_LSB = 0;
   localparam int CTRL_HOLD_BIT   = 8;
   localparam int STAT_ACTIVE_LSB = 0;
   localparam int STAT_BUSY_BIT   = 8;
   localparam int STAT_ERR_BIT    = 9;

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rst_sync : 2-flop active-low reset synchronizer, async assert /    |
// |            sync deassert                                           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rst_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_rst_n
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= 1'b1;
         r_sync <= r_meta;
      end
   end

   assign o_rst_n = r_sync;

endmodule
`default_nettype wire

// File: rtl/design_select_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | design_select_mux : Wishbone-selected pad mux for hosted designs   |
// |                     with isolate / reset / release switch sequence |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module design_select_mux
   import design_mux_pkg::*;
#(
   parameter int          NUM_DESIGNS  = 4,
   parameter int          IO_WIDTH     = 33,
   parameter int          GUARD_CYCLES = 4,
   parameter int          RESET_CYCLES = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
   input  logic                            wb_clk_i,
   input  logic                            wb_rst_i,
   input  logic                            wbs_cyc_i,
   input  logic                            wbs_stb_i,
   input  logic                            wbs_we_i,
   input  logic [3:0]                      wbs_sel_i,
   input  logic [31:0]                     wbs_adr_i,
   input  logic [31:0]                     wbs_dat_i,
   output logic                            wbs_ack_o,
   output logic [31:0]                     wbs_dat_o,
   input  logic                            ext_rst_n_i,
   input  logic [NUM_DESIGNS*IO_WIDTH-1:0] d_io_out,
   input  logic [NUM_DESIGNS*IO_WIDTH-1:0] d_io_oeb,
   output logic [NUM_DESIGNS-1:0]          d_rst_n,
   output logic [IO_WIDTH-1:0]             io_out,
   output logic [IO_WIDTH-1:0]             io_oeb
);

   localparam int SEL_W   = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1;
   localparam int MAX_CYC = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);

   mux_state_e          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [7:0]          r_target;
   logic [7:0]          r_active;
   logic                r_hold;
   logic                r_err;
   logic                r_ack;
   logic [31:0]         r_dat;

   logic                w_pad_rst_n;
   logic                w_req;
   logic                w_ctrl_wr;
   logic                w_tgt_ok;
   logic                w_start;
   logic                w_busy;
   logic [31:0]         w_rdata;
   logic [SEL_W-1:0]    w_act_idx;
   logic [IO_WIDTH-1:0] w_slice_out [NUM_DESIGNS];
   logic [IO_WIDTH-1:0] w_slice_oeb [NUM_DESIGNS];
   logic                w_unused;

   rst_sync u_pad_sync (
      .i_clk   (wb_clk_i),
      .i_rst_n (ext_rst_n_i),
      .o_rst_n (w_pad_rst_n)
   );

   assign w_req     = wbs_cyc_i & wbs_stb_i & ~r_ack & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_ctrl_wr = w_req & wbs_we_i & (wbs_adr_i[3:0] == CTRL_OFS);
   assign w_tgt_ok  = ({24'd0, wbs_dat_i[7:0]} < 32'(NUM_DESIGNS));
   // Only a write that actually carries the target byte can launch a switch;
   // a hold-only write (sel[1] without sel[0]) just updates the hold bit.
   assign w_start   = w_ctrl_wr & wbs_sel_i[0] & w_tgt_ok;
   assign w_busy    = (r_state != RUN);
   assign w_unused  = ^{wbs_sel_i[3:2], wbs_dat_i[31:9]};

   always_comb begin
      w_rdata = '0;
      if (wbs_adr_i[3:0] == CTRL_OFS) begin
         w_rdata[CTRL_TARGET_LSB +: 8] = r_target;
         w_rdata[CTRL_HOLD_BIT]        = r_hold;
      end else if (wbs_adr_i[3:0] == STATUS_OFS) begin
         w_rdata[STAT_ACTIVE_LSB +: 8] = r_active;
         w_rdata[STAT_BUSY_BIT]        = w_busy;
         w_rdata[STAT_ERR_BIT]         = r_err;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_target <= '0;
         r_hold   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req & ~wbs_we_i) ? w_rdata : '0;
         if (w_ctrl_wr) begin
            if (wbs_sel_i[0]) begin
               if (w_tgt_ok) begin
                  r_target <= wbs_dat_i[7:0];
                  r_err    <= 1'b0;
               end else begin
                  r_err    <= 1'b1;
               end
            end
            if (wbs_sel_i[1]) begin
               r_hold <= wbs_dat_i[CTRL_HOLD_BIT];
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state  <= RESET;
         r_cnt    <= '0;
         r_active <= '0;
      end else if (w_start) begin
         r_state <= ISOLATE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            RUN: begin
               r_cnt <= '0;
            end
            ISOLATE: begin
               if (r_cnt >= GUARD_LAST) begin
                  r_state  <= RESET;
                  r_cnt    <= '0;
                  r_active <= r_target;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESET: begin
               // Counter parks at its last value while hold keeps the design in reset.
               if (r_cnt >= RESET_LAST) begin
                  if (!r_hold) begin
                     r_state <= RUN;
                     r_cnt   <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= RESET;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   generate
      for (genvar k = 0; k < NUM_DESIGNS; k++) begin : g_slice
         assign w_slice_out[k] = d_io_out[k*IO_WIDTH +: IO_WIDTH];
         assign w_slice_oeb[k] = d_io_oeb[k*IO_WIDTH +: IO_WIDTH];
         assign d_rst_n[k]     = (r_state == RUN) && (r_active == 8'(k)) && w_pad_rst_n;
      end
   endgenerate

   assign w_act_idx = r_active[SEL_W-1:0];
   assign io_out    = ((r_state == ISOLATE) || wb_rst_i) ? '0 : w_slice_out[w_act_idx];
   assign io_oeb    = (r_state == RUN) ? w_slice_oeb[w_act_idx] : '1;

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_design_select_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_design_select_mux : self-checking bench with a timing-level     |
// |                        model of the switch sequence               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_design_select_mux;

   localparam int N = 4;
   localparam int W = 33;
   localparam int G = 4;
   localparam int R = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          cyc_i, stb, we;
   logic [3:0]    sel;
   logic [31:0]   adr, wdat, rdat;
   logic          ack;
   logic          ext_rst_n;
   logic [N*W-1:0] dout, doeb;
   logic [N-1:0]  drst;
   logic [W-1:0]  io_out, io_oeb;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   // Model: last accepted switch launched at cycle m_N toward m_tgt; m_prev was active before it.
   int m_N, m_tgt, m_prev, m_err;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   design_select_mux #(
      .NUM_DESIGNS(N), .IO_WIDTH(W), .GUARD_CYCLES(G), .RESET_CYCLES(R), .BASE_ADDR(BASE)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc_i), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .ext_rst_n_i(ext_rst_n), .d_io_out(dout), .d_io_oeb(doeb), .d_rst_n(drst),
      .io_out(io_out), .io_oeb(io_oeb)
   );

   function automatic bit m_busy(int c);
      return (c > m_N) && (c <= m_N + G + R);
   endfunction
   function automatic bit m_iso(int c);
      return (c > m_N) && (c <= m_N + G);
   endfunction
   function automatic int m_act(int c);
      return (c > m_N + G) ? m_tgt : m_prev;
   endfunction
   function automatic void m_write(int c, int t);
      m_prev = m_act(c);
      m_N    = c;
      m_tgt  = t;
      m_err  = 0;
   endfunction
   function automatic logic [W-1:0] exp_out(int c);
      if (m_iso(c)) return '0;
      return dout[m_act(c)*W +: W];
   endfunction
   function automatic logic [W-1:0] exp_oeb(int c);
      if (m_busy(c)) return '1;
      return doeb[m_act(c)*W +: W];
   endfunction
   function automatic logic [N-1:0] exp_rst(int c);
      logic [N-1:0] v;
      v = '0;
      if (!m_busy(c)) v[m_act(c)] = 1'b1;
      return v;
   endfunction
   function automatic logic [31:0] exp_status(int c);
      return {22'd0, m_err[0], m_busy(c), 8'(m_act(c))};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output bit got, output logic [31:0] rd,
                            output int ack_cyc);
      cyc_i = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      got = 1'b0; rd = '0; ack_cyc = -1;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk);
         #1;
         if (ack === 1'b1) begin
            got = 1'b1; rd = rdat; ack_cyc = cyc;
         end
      end
      cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic test_reset();
      int c0;
      rst = 1'b1; ext_rst_n = 1'b0;
      cyc_i = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
      for (int j = 0; j < N*W; j++) begin dout[j] = 1'($urandom); doeb[j] = 1'($urandom); end
      tick(3);
      ext_rst_n = 1'b1;
      tick(3);
      n_chk++; if (ack !== 1'b0) $display("FAIL rst_ack: got %b exp 0", ack); else n_pass++;
      n_chk++; if (rdat !== 32'd0) $display("FAIL rst_dat: got %h exp 0", rdat); else n_pass++;
      n_chk++; if (drst !== '0) $display("FAIL rst_drst: got %b exp 0", drst); else n_pass++;
      n_chk++; if (io_oeb !== '1) $display("FAIL rst_oeb: got %h exp all 1", io_oeb); else n_pass++;
      n_chk++; if (io_out !== '0) $display("FAIL rst_out: got %h exp 0", io_out); else n_pass++;
      rst = 1'b0;
      c0 = cyc;
      m_N = c0 - G - 1; m_tgt = 0; m_prev = 0; m_err = 0;
      for (int k = 1; k <= R + 1; k++) begin
         if (k > 1) tick(1);
         if (k <= R) begin
            n_chk++; if (io_oeb !== '1 || drst !== '0)
               $display("FAIL rel_hold c%0d: oeb %h drst %b exp all1/0", k, io_oeb, drst); else n_pass++;
         end else begin
            n_chk++; if (drst !== 4'b0001) $display("FAIL rel_drst: got %b exp 0001", drst); else n_pass++;
            n_chk++; if (io_out !== dout[W-1:0]) $display("FAIL rel_out: got %h exp %h", io_out, dout[W-1:0]); else n_pass++;
            n_chk++; if (io_oeb !== doeb[W-1:0]) $display("FAIL rel_oeb: got %h exp %h", io_oeb, doeb[W-1:0]); else n_pass++;
         end
      end
   endtask

   task automatic test_switch();
      bit got; logic [31:0] rd; int ac, c;
      tick(1);
      c = cyc;
      wb_access(BASE, 1'b1, 32'h0000_0002, 4'b0001, got, rd, ac);
      n_chk++; if (!got || ac != c + 1) $display("FAIL sw_ack: ack cycle %0d exp %0d", ac, c + 1); else n_pass++;
      m_write(ac - 1, 2);
      wb_access(BASE + 4, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== exp_status(ac - 1) || rd[8] !== 1'b1)
         $display("FAIL sw_busy: got %h exp %h", rd, exp_status(ac - 1)); else n_pass++;
      while (cyc <= m_N + G + R + 1) begin
         n_chk++; if (drst !== exp_rst(cyc)) $display("FAIL sw_drst c%0d: got %b exp %b", cyc - m_N, drst, exp_rst(cyc)); else n_pass++;
         tick(1);
      end
      n_chk++; if (drst !== 4'b0100) $display("FAIL sw_final: got %b exp 0100", drst); else n_pass++;
      wb_access(BASE + 4, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== 32'h002) $display("FAIL sw_status: got %h exp 002", rd); else n_pass++;
   endtask

   task automatic test_invalid();
      bit got; logic [31:0] rd; int ac;
      wb_access(BASE, 1'b1, 32'h0000_0007, 4'b0001, got, rd, ac);
      m_err = 1;
      n_chk++; if (!got) $display("FAIL inv_ack: got 0 exp 1"); else n_pass++;
      tick(2);
      n_chk++; if (drst !== 4'b0100) $display("FAIL inv_noseq: got %b exp 0100", drst); else n_pass++;
      wb_access(BASE + 4, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== 32'h202) $display("FAIL inv_status: got %h exp 202", rd); else n_pass++;
      wb_access(BASE + 8, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== 32'd0) $display("FAIL other_ofs: got %h ack %b exp 0 ack 1", rd, got); else n_pass++;
      wb_access(BASE, 1'b1, 32'h0000_0001, 4'b0001, got, rd, ac);
      m_write(ac - 1, 1);
      wb_access(BASE + 4, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== exp_status(ac - 1) || rd[9] !== 1'b0)
         $display("FAIL inv_clr: got %h exp %h", rd, exp_status(ac - 1)); else n_pass++;
      while (cyc <= m_N + G + R + 1) tick(1);
      n_chk++; if (drst !== 4'b0010) $display("FAIL inv_final: got %b exp 0010", drst); else n_pass++;
   endtask

   task automatic test_hold();
      bit got; logic [31:0] rd; int ac;
      wb_access(BASE, 1'b1, 32'h0000_0101, 4'b0011, got, rd, ac);
      tick(G + R + 10);
      n_chk++; if (drst !== '0 || io_oeb !== '1)
         $display("FAIL hold_stay: drst %b oeb %h exp 0/all1", drst, io_oeb); else n_pass++;
      n_chk++; if (io_out !== dout[W +: W]) $display("FAIL hold_out: got %h exp %h", io_out, dout[W +: W]); else n_pass++;
      wb_access(BASE, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== 32'h101) $display("FAIL hold_ctrl: got %h exp 101", rd); else n_pass++;
      wb_access(BASE + 4, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== 32'h101) $display("FAIL hold_status: got %h exp 101", rd); else n_pass++;
      wb_access(BASE, 1'b1, 32'h0000_0001, 4'b0010, got, rd, ac);
      tick(1);
      n_chk++; if (drst !== 4'b0010) $display("FAIL hold_rel: got %b exp 0010", drst); else n_pass++;
      n_chk++; if (io_oeb !== doeb[W +: W]) $display("FAIL hold_oeb: got %h exp %h", io_oeb, doeb[W +: W]); else n_pass++;
      m_N = cyc - 1000; m_tgt = 1; m_prev = 1;
   endtask

   task automatic test_restart();
      bit got; logic [31:0] rd; int ac, n1;
      tick(1);
      wb_access(BASE, 1'b1, 32'h0000_0003, 4'b0001, got, rd, ac);
      n1 = ac - 1;
      m_write(n1, 3);
      while (cyc < n1 + 10) begin
         n_chk++; if (io_out !== exp_out(cyc) || io_oeb !== exp_oeb(cyc))
            $display("FAIL rs_io1 c%0d: out %h oeb %h", cyc - n1, io_out, io_oeb); else n_pass++;
         tick(1);
      end
      wb_access(BASE, 1'b1, 32'h0000_0000, 4'b0001, got, rd, ac);
      n_chk++; if (ac - 1 != n1 + 10) $display("FAIL rs_when: write cycle %0d exp %0d", ac - 1 - n1, 10); else n_pass++;
      m_write(ac - 1, 0);
      while (cyc <= m_N + G + R + 1) begin
         n_chk++; if (drst !== exp_rst(cyc) || io_out !== exp_out(cyc) || io_oeb !== exp_oeb(cyc))
            $display("FAIL rs_io2 c%0d: drst %b out %h oeb %h exp %b %h %h", cyc - m_N, drst, io_out, io_oeb,
                     exp_rst(cyc), exp_out(cyc), exp_oeb(cyc)); else n_pass++;
         tick(1);
      end
      n_chk++; if (drst !== 4'b0001) $display("FAIL rs_final: got %b exp 0001", drst); else n_pass++;
   endtask

   task automatic test_ext_reset();
      bit got; logic [31:0] rd; int ac;
      tick(2);
      #2;
      ext_rst_n = 1'b0;
      #1;
      n_chk++; if (drst !== 4'b0000) $display("FAIL ext_async: got %b exp 0000", drst); else n_pass++;
      n_chk++; if (io_oeb !== doeb[W-1:0]) $display("FAIL ext_oeb: got %h exp %h", io_oeb, doeb[W-1:0]); else n_pass++;
      @(posedge clk);
      #1;
      tick(2);
      ext_rst_n = 1'b1;
      #1;
      n_chk++; if (drst !== 4'b0000) $display("FAIL ext_rel0: got %b exp 0000", drst); else n_pass++;
      tick(1);
      n_chk++; if (drst !== 4'b0000) $display("FAIL ext_rel1: got %b exp 0000", drst); else n_pass++;
      tick(1);
      n_chk++; if (drst !== 4'b0001) $display("FAIL ext_rel2: got %b exp 0001", drst); else n_pass++;
      wb_access(BASE + 4, 1'b0, 32'd0, 4'b1111, got, rd, ac);
      n_chk++; if (!got || rd !== 32'h000) $display("FAIL ext_status: got %h exp 000", rd); else n_pass++;
   endtask

   task automatic test_random();
      bit pend, pend_rd;
      logic [31:0] pend_exp;
      int c, op, t;
      pend = 1'b0; pend_rd = 1'b0; pend_exp = '0;
      tick(1);
      for (int i = 0; i < 400; i++) begin
         for (int j = 0; j < N*W; j++) begin dout[j] = 1'($urandom); doeb[j] = 1'($urandom); end
         #1;
         c = cyc;
         n_chk++; if (io_out !== exp_out(c) || io_oeb !== exp_oeb(c) || drst !== exp_rst(c))
            $display("FAIL rnd_io i%0d: out %h oeb %h drst %b exp %h %h %b", i, io_out, io_oeb, drst,
                     exp_out(c), exp_oeb(c), exp_rst(c)); else n_pass++;
         if (pend) begin
            n_chk++; if (ack !== 1'b1) $display("FAIL rnd_ack i%0d: got %b exp 1", i, ack); else n_pass++;
            if (pend_rd) begin
               n_chk++; if (rdat !== pend_exp) $display("FAIL rnd_rd i%0d: got %h exp %h", i, rdat, pend_exp); else n_pass++;
            end
            cyc_i = 1'b0; stb = 1'b0; we = 1'b0; pend = 1'b0;
         end else if ($urandom_range(0, 5) == 0) begin
            op = $urandom_range(0, 2);
            cyc_i = 1'b1; stb = 1'b1; sel = 4'b0001; pend = 1'b1; pend_rd = (op == 2);
            if (op == 0) begin
               t = $urandom_range(0, N - 1);
               adr = BASE; we = 1'b1; wdat = 32'(t);
               m_write(c, t);
            end else if (op == 1) begin
               t = $urandom_range(N, 255);
               adr = BASE; we = 1'b1; wdat = 32'(t);
               m_err = 1;
            end else begin
               adr = BASE + 4; we = 1'b0; wdat = '0;
               pend_exp = exp_status(c);
            end
         end
         @(posedge clk);
         #1;
      end
      cyc_i = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_switch();
      test_invalid();
      test_hold();
      test_restart();
      test_ext_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
